// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: fetch FSM states, default widths and the
// encoding of the three ways fetch can steer the program counter.
package instr_fetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // PC_CTRL_HOLD reloads the current count, PC_CTRL_ADV lets the counter
    // step up by one, PC_CTRL_JMP loads the redirect target.
    typedef enum logic [1:0] {
        PC_CTRL_HOLD = 2'd0,
        PC_CTRL_ADV  = 2'd1,
        PC_CTRL_JMP  = 2'd2
    } pc_ctrl_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage sitting behind the free-running PC counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ISSUE | strobe the program memory at the current PC, latch ir_pc
// ST_WAIT  | down-count the read latency, capture data at terminal count
// ST_HOLD  | present instruction to decode until it is accepted
//
// The counter steps on every clock, so the PC is held by reloading its own
// value; it only advances in the cycle decode accepts an instruction.
// A jump wins over everything and discards any read still in flight.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  i_pc_in,
    output logic               o_pc_load,
    output logic [ADDR_W-1:0]  o_pc_data,
    output logic               o_pc_up_down,
    output logic               o_mem_rd,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic               o_ir_valid,
    input  logic               i_ir_ready,
    output logic [INSTR_W-1:0] o_ir_data,
    output logic [ADDR_W-1:0]  o_ir_pc,
    input  logic               i_jmp_valid,
    input  logic [ADDR_W-1:0]  i_jmp_target
);

    localparam int CNT_W = $clog2(ROM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    pc_ctrl_t           w_pc_ctrl;
    logic               w_mem_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ir_valid;
    logic [INSTR_W-1:0] r_ir_data;
    logic [ADDR_W-1:0]  r_ir_pc;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, read strobe and PC steering; a jump overrides all states.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_ctrl   = PC_CTRL_HOLD;
        w_mem_rd    = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                w_mem_rd    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ir_ready) begin
                    w_pc_ctrl   = PC_CTRL_ADV;
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase
        if (i_jmp_valid) begin
            // The read would be thrown away, so do not start it.
            w_pc_ctrl   = PC_CTRL_JMP;
            w_mem_rd    = 1'b0;
            w_state_nxt = ST_ISSUE;
        end
    end

    // Latency down-counter and instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_ir_valid <= 1'b0;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
        end else if (i_jmp_valid) begin
            r_cnt      <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    r_ir_pc <= i_pc_in;
                    r_cnt   <= CNT_INIT;
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_ir_data  <= i_mem_rdata;
                        r_ir_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_ir_ready) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign o_pc_load    = ~reset & (w_pc_ctrl != PC_CTRL_ADV);
    assign o_pc_data    = reset ? '0 :
                          (w_pc_ctrl == PC_CTRL_JMP) ? i_jmp_target : i_pc_in;
    assign o_pc_up_down = ~reset;
    assign o_mem_rd     = ~reset & w_mem_rd;
    assign o_mem_addr   = reset ? '0 : i_pc_in;

    assign o_ir_valid = r_ir_valid;
    assign o_ir_data  = r_ir_data;
    assign o_ir_pc    = r_ir_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (read latency 1 and 3), each wrapped
// with a model of the PC counter and a fixed-latency program memory.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [15:0] rom_f(input logic [7:0] a);
        if (a == 8'h00) return 16'h1234;
        return {~a, a};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // ---------------- instance A, ROM_LAT = 1 ----------------
    logic        reset_a, rdy_a, jv_a;
    logic [7:0]  jt_a, pc_a, data_a, addr_a, irpc_a;
    logic        load_a, ud_a, rd_a, valid_a;
    logic [15:0] rdata_a, ir_a;
    logic [7:0]  pa_a;
    logic        v_a = 1'b0;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a)     pc_a <= 8'h00;
        else if (load_a) pc_a <= data_a;
        else if (ud_a)   pc_a <= pc_a + 8'h01;
        else             pc_a <= pc_a - 8'h01;
    end

    always @(posedge clk) begin
        pa_a <= addr_a;
        v_a  <= rd_a;
    end
    assign rdata_a = v_a ? rom_f(pa_a) : 16'hDEAD;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .ROM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset_a), .i_pc_in(pc_a),
        .o_pc_load(load_a), .o_pc_data(data_a), .o_pc_up_down(ud_a),
        .o_mem_rd(rd_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a),
        .o_ir_valid(valid_a), .i_ir_ready(rdy_a), .o_ir_data(ir_a),
        .o_ir_pc(irpc_a), .i_jmp_valid(jv_a), .i_jmp_target(jt_a)
    );

    // ---------------- instance B, ROM_LAT = 3 ----------------
    logic        reset_b, rdy_b, jv_b;
    logic [7:0]  jt_b, pc_b, data_b, addr_b, irpc_b;
    logic        load_b, ud_b, rd_b, valid_b;
    logic [15:0] rdata_b, ir_b;
    logic [7:0]  pa_b [3];
    logic [2:0]  v_b = 3'b000;

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b)     pc_b <= 8'h00;
        else if (load_b) pc_b <= data_b;
        else if (ud_b)   pc_b <= pc_b + 8'h01;
        else             pc_b <= pc_b - 8'h01;
    end

    // Memory pipeline is not reset, so a read issued before a reset still
    // returns data afterwards.
    always @(posedge clk) begin
        pa_b[0] <= addr_b;
        pa_b[1] <= pa_b[0];
        pa_b[2] <= pa_b[1];
        v_b     <= {v_b[1:0], rd_b};
    end
    assign rdata_b = v_b[2] ? rom_f(pa_b[2]) : 16'hDEAD;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .ROM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset_b), .i_pc_in(pc_b),
        .o_pc_load(load_b), .o_pc_data(data_b), .o_pc_up_down(ud_b),
        .o_mem_rd(rd_b), .o_mem_addr(addr_b), .i_mem_rdata(rdata_b),
        .o_ir_valid(valid_b), .i_ir_ready(rdy_b), .o_ir_data(ir_b),
        .o_ir_pc(irpc_b), .i_jmp_valid(jv_b), .i_jmp_target(jt_b)
    );

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic        rdy;
        logic        jv;
        logic [7:0]  jt;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic        e_load;
        logic [7:0]  e_data;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [7:0]  e_irpc;
        logic [7:0]  e_pc;
    } vec_t;

    localparam int NV = 28;
    vec_t tv [NV];

    initial begin
        //          rdy   jv    jt     rd    addr   load  data   valid ir        irpc   pc
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
        tv[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
        tv[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h00};
        tv[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 16'h1234, 8'h00, 8'h01};
        tv[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b0, 16'h1234, 8'h01, 8'h01};
        // backpressure: five cycles with ir_ready low
        tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h01, 1'b1, 16'hFE01, 8'h01, 8'h01};
        tv[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h02, 1'b0, 16'hFE01, 8'h01, 8'h02};
        // jump during WAIT: data for 0x02 must never appear
        tv[12] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h02, 1'b1, 8'h40, 1'b0, 16'hFE01, 8'h02, 8'h02};
        tv[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 16'hFE01, 8'h02, 8'h40};
        tv[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 8'h40, 1'b0, 16'hFE01, 8'h40, 8'h40};
        // jump in HOLD without handshake drops the pending instruction
        tv[15] = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h40, 1'b1, 8'h10, 1'b1, 16'hBF40, 8'h40, 8'h40};
        tv[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0, 16'hBF40, 8'h40, 8'h10};
        tv[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b1, 8'h10, 1'b0, 16'hBF40, 8'h10, 8'h10};
        // handshake and jump together: PC takes 0x80, not 0x11
        tv[18] = '{1'b1, 1'b1, 8'h80, 1'b0, 8'h10, 1'b1, 8'h80, 1'b1, 16'hEF10, 8'h10, 8'h10};
        tv[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 8'h80, 1'b0, 16'hEF10, 8'h10, 8'h80};
        tv[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b1, 8'h80, 1'b0, 16'hEF10, 8'h80, 8'h80};
        tv[21] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h80, 1'b1, 8'hFF, 1'b1, 16'h7F80, 8'h80, 8'h80};
        tv[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 16'h7F80, 8'h80, 8'hFF};
        tv[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0, 16'h7F80, 8'hFF, 8'hFF};
        // accept at 0xFF: PC wraps to 0x00
        tv[24] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b1, 16'h00FF, 8'hFF, 8'hFF};
        tv[25] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 16'h00FF, 8'hFF, 8'h00};
        tv[26] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h00FF, 8'h00, 8'h00};
        tv[27] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h00};
    end

    initial begin
        reset_a = 1'b1; rdy_a = 1'b0; jv_a = 1'b0; jt_a = 8'h00;
        reset_b = 1'b1; rdy_b = 1'b0; jv_b = 1'b0; jt_b = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ir_valid", 0, 32'(valid_a), 32'h0);
        chk("rst_ir_data",  0, 32'(ir_a),    32'h0);
        chk("rst_ir_pc",    0, 32'(irpc_a),  32'h0);
        chk("rst_mem_rd",   0, 32'(rd_a),    32'h0);
        chk("rst_pc_load",  0, 32'(load_a),  32'h0);
        chk("rst_up_down",  0, 32'(ud_a),    32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i == 0) reset_a = 1'b0;
            rdy_a = tv[i].rdy;
            jv_a  = tv[i].jv;
            jt_a  = tv[i].jt;
            #1;
            chk("mem_rd",     i, 32'(rd_a),    32'(tv[i].e_rd));
            chk("mem_addr",   i, 32'(addr_a),  32'(tv[i].e_addr));
            chk("pc_load",    i, 32'(load_a),  32'(tv[i].e_load));
            chk("pc_data",    i, 32'(data_a),  32'(tv[i].e_data));
            chk("pc_up_down", i, 32'(ud_a),    32'h1);
            chk("ir_valid",   i, 32'(valid_a), 32'(tv[i].e_valid));
            chk("ir_data",    i, 32'(ir_a),    32'(tv[i].e_ir));
            chk("ir_pc",      i, 32'(irpc_a),  32'(tv[i].e_irpc));
            chk("pc",         i, 32'(pc_a),    32'(tv[i].e_pc));
        end
        @(negedge clk);
        rdy_a = 1'b0;

        // ROM_LAT=3: ISSUE at cycle 0, ir_valid from cycle 4
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("b_issue_rd",   0, 32'(rd_b),   32'h1);
        chk("b_issue_addr", 0, 32'(addr_b), 32'h00);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            chk("b_lat_valid", k, 32'(valid_b), 32'h0);
        end
        @(negedge clk);
        rdy_b = 1'b1;
        #1;
        chk("b_valid_c4", 4, 32'(valid_b), 32'h1);
        chk("b_data_c4",  4, 32'(ir_b),    32'h1234);
        chk("b_irpc_c4",  4, 32'(irpc_b),  32'h00);
        @(negedge clk);
        rdy_b = 1'b0;
        #1;
        chk("b_issue2_rd",   5, 32'(rd_b),    32'h1);
        chk("b_issue2_addr", 5, 32'(addr_b),  32'h01);
        chk("b_issue2_vld",  5, 32'(valid_b), 32'h0);
        @(negedge clk); #1;
        chk("b_wait_valid", 6, 32'(valid_b), 32'h0);
        @(negedge clk); #1;
        chk("b_wait_irpc", 7, 32'(irpc_b), 32'h01);

        // reset mid-WAIT with the read for 0x01 still in flight
        #1 reset_b = 1'b1;
        #1;
        chk("b_rst_valid",  7, 32'(valid_b), 32'h0);
        chk("b_rst_mem_rd", 7, 32'(rd_b),    32'h0);
        chk("b_rst_load",   7, 32'(load_b),  32'h0);
        chk("b_rst_irpc",   7, 32'(irpc_b),  32'h0);
        chk("b_rst_irdata", 7, 32'(ir_b),    32'h0);
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("b_restart_rd",   8, 32'(rd_b),   32'h1);
        chk("b_restart_addr", 8, 32'(addr_b), 32'h00);
        for (int k = 9; k <= 11; k++) begin
            @(negedge clk); #1;
            chk("b_restart_valid", k, 32'(valid_b), 32'h0);
        end
        @(negedge clk); #1;
        chk("b_restart_v12",  12, 32'(valid_b), 32'h1);
        chk("b_restart_d12",  12, 32'(ir_b),    32'h1234);
        chk("b_restart_pc12", 12, 32'(irpc_b),  32'h00);
        @(negedge clk); #1;
        chk("b_hold_valid", 13, 32'(valid_b), 32'h1);

        // asynchronous drop of a presented instruction
        #2 reset_b = 1'b1;
        #1;
        chk("b_async_valid", 13, 32'(valid_b), 32'h0);
        chk("b_async_data",  13, 32'(ir_b),    32'h0);
        @(negedge clk);
        reset_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the 8-bit program counter.
- Takes the counter value as the instruction address and reads a fixed-latency program memory.
- Presents the fetched instruction to decode over a valid/ready handshake.
- Steers the counter's load/data/up_down inputs. The counter changes on every clock, so this block holds the PC by reloading it, advances it by one on each accepted instruction, and loads it on a jump.

Parameters:
- ADDR_W, 8, width of the PC and of the memory address.
- INSTR_W, 16, instruction word width.
- ROM_LAT, 1, program memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_W  current PC count.
- pc_load  out  1  drives the counter's load input.
- pc_data  out  ADDR_W  drives the counter's data input.
- pc_up_down  out  1  drives the counter's up_down input.
- mem_rd  out  1  read strobe, one cycle per fetch.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  INSTR_W  read data, valid exactly ROM_LAT cycles after the mem_rd cycle.
- ir_valid  out  1  instruction available to decode.
- ir_ready  in  1  decode accepts the instruction.
- ir_data  out  INSTR_W  instruction register.
- ir_pc  out  ADDR_W  address the instruction was fetched from.
- jmp_valid  in  1  redirect request from decode/execute.
- jmp_target  in  ADDR_W  redirect address.

Behaviour:
- Reset (asynchronous): state=ISSUE, ir_valid=0, ir_data=0, ir_pc=0, latency counter=0.
- While reset is high, all combinational outputs are forced to 0.
- FSM, three states:
  - ISSUE: mem_rd=1, mem_addr=pc_in; ir_pc<=pc_in; cnt<=ROM_LAT-1; go to WAIT.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0, ir_data<=mem_rdata, ir_valid<=1, go to HOLD.
  - HOLD: ir_valid=1. On ir_valid&&ir_ready: ir_valid<=0, go to ISSUE.
- PC control:
  - Default in every state is hold: pc_load=1, pc_data=pc_in, pc_up_down=1.
  - Advance happens only in the HOLD handshake cycle: pc_load=0, pc_up_down=1, so the PC becomes pc+1 at that edge.
  - pc_up_down is never driven 0; down-counting is not used by fetch.
- Jump has the highest priority and is accepted in any state:
  - pc_load=1, pc_data=jmp_target.
  - Next state is ISSUE, ir_valid<=0, cnt cleared.
  - Any in-flight read is discarded; its data is never presented.
- Jump and handshake in the same HOLD cycle: the transfer counts as completed, and the PC takes jmp_target, not pc+1.
- Latency: ISSUE at cycle t, capture at the end of cycle t+ROM_LAT, ir_valid high from cycle t+ROM_LAT+1.
- Peak throughput: one instruction per ROM_LAT+2 cycles with ir_ready held high.
- Backpressure: in HOLD with ir_ready=0, ir_data and ir_pc are stable and the PC is held indefinitely.
- Wrap-around: advance from 2^ADDR_W-1 gives 0; no special handling and no flag.
- Reset mid-fetch: ir_valid drops immediately, and the stale memory return is ignored.
- Unsigned arithmetic throughout; cnt is $clog2(ROM_LAT)+1 bits wide.

Decomposition:
- Shared cpu package holds:
  - the fetch state enum (ISSUE, WAIT, HOLD);
  - ADDR_W/INSTR_W defaults;
  - the PC control encoding constants (HOLD, ADV, JMP).
- No sub-module: the FSM, latency counter and instruction register fit in one module of about 150-200 lines.

Test Plan:
1. ROM_LAT=1, memory[0x00]=0x1234, ir_ready=1, release reset at cycle 0:
   - mem_rd=1 with mem_addr=0x00 in cycle 0;
   - ir_valid=1, ir_data=0x1234, ir_pc=0x00 in cycle 2;
   - pc_load=0 in cycle 2, PC=0x01 in cycle 3.
2. Backpressure, ir_ready=0 for 5 cycles in HOLD:
   - ir_valid, ir_data and ir_pc are stable; pc_load=1 and pc_data=pc_in every cycle; PC unchanged;
   - raising ir_ready gives exactly one advance.
3. jmp_valid=1 with jmp_target=0x40 during WAIT:
   - pc_load=1 with pc_data=0x40;
   - next ISSUE has mem_addr=0x40;
   - the old address's data is never seen on ir_data; ir_pc=0x40.
4. In HOLD with PC=0x10, ir_ready=1 and jmp_valid=1 with target 0x80 in the same cycle:
   - PC becomes 0x80, not 0x11;
   - next fetch is from 0x80.
5. PC=0xFF instruction accepted -> next mem_addr=0x00 and ir_pc=0x00.
6. ROM_LAT=3:
   - ir_valid rises exactly 4 cycles after the ISSUE cycle;
   - reset asserted mid-WAIT drops ir_valid asynchronously, and fetch restarts in ISSUE after release.
